// File: rtl/plru_state_array.sv
// Per-set 3-bit tree-PLRU state for a 4-way cache.
// A sweep clears every set after reset or flush; reads have one-cycle latency.
module plru_state_array #(
  parameter int NUM_SETS = 16,
  parameter int IDX_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  output logic             ready,
  input  logic             rd_valid,
  input  logic [IDX_W-1:0] rd_index,
  output logic [2:0]       plru_out,
  output logic             plru_valid,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic [1:0]       upd_way
);

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] IDLE = 1'b1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SETS - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [2:0]       out_q, out_d;
  logic             vld_q, vld_d;

  logic [2:0] mem_q [NUM_SETS];

  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [2:0]       wdata;
  logic [2:0]       upd_cur;
  logic [2:0]       upd_new;

  assign upd_cur = mem_q[upd_index];

  // Point the tree away from the accessed way; untouched branch keeps its bit.
  always_comb begin
    unique case (upd_way)
      2'd0:    upd_new = {2'b11, upd_cur[0]};
      2'd1:    upd_new = {2'b10, upd_cur[0]};
      2'd2:    upd_new = {1'b0, upd_cur[1], 1'b1};
      default: upd_new = {1'b0, upd_cur[1], 1'b0};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    we      = 1'b0;
    waddr   = cnt_q;
    wdata   = 3'b000;
    if (state_q == INIT) begin
      if (flush) begin
        cnt_d = '0;
      end else begin
        we    = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = IDLE;
      end
    end else if (flush) begin
      state_d = INIT;
      cnt_d   = '0;
    end else begin
      if (upd_valid) begin
        we    = 1'b1;
        waddr = upd_index;
        wdata = upd_new;
      end
      if (rd_valid) begin
        vld_d = 1'b1;
        out_d = (upd_valid && upd_index == rd_index) ? upd_new
                                                     : mem_q[rd_index];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      out_q   <= 3'b000;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  // Entries have no reset of their own; only the sweep clears them.
  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[waddr] <= wdata;
  end

  assign ready      = (state_q == IDLE);
  assign plru_out   = out_q;
  assign plru_valid = vld_q;

endmodule

// File: tb/tb_plru_state_array.sv
// Randomised and directed bench for plru_state_array.
// Reference model tracks most-recently-used pair/way per set.
module tb_plru_state_array;

  localparam int NS = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          ready;
  logic          rd_valid = 1'b0;
  logic [IW-1:0] rd_index = '0;
  logic [2:0]    plru_out;
  logic          plru_valid;
  logic          upd_valid = 1'b0;
  logic [IW-1:0] upd_index = '0;
  logic [1:0]    upd_way = '0;

  always #5 clk = ~clk;

  plru_state_array #(.NUM_SETS(NS), .IDX_W(IW)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .ready(ready),
    .rd_valid(rd_valid),
    .rd_index(rd_index),
    .plru_out(plru_out),
    .plru_valid(plru_valid),
    .upd_valid(upd_valid),
    .upd_index(upd_index),
    .upd_way(upd_way)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int         kind;
    logic [2:0] val;
  } exp_t;
  exp_t sbq[$];

  int mru_pair [NS];
  int mru0 [NS];
  int mru1 [NS];
  bit m_init = 1'b1;
  int m_cnt = 0;
  bit armed = 1'b0;
  logic [2:0] last_out = 3'b000;

  function automatic logic [2:0] tree(input int s);
    return {mru_pair[s] == 0, mru0[s] == 0, mru1[s] == 2};
  endfunction

  function automatic void touch(input int s, input int w);
    if (w < 2) begin
      mru_pair[s] = 0;
      mru0[s] = w;
    end else begin
      mru_pair[s] = 1;
      mru1[s] = w;
    end
  endfunction

  function automatic void forget(input int s);
    mru_pair[s] = 1;
    mru0[s] = 1;
    mru1[s] = 3;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit f, input bit rv,
                       input int ri, input bit uv, input int ui,
                       input int uw);
    exp_t e;
    @(negedge clk);
    if (armed) chk("ready", {7'd0, ready}, {7'd0, !m_init});
    rst = r;
    flush = f;
    rd_valid = rv;
    rd_index = ri[IW-1:0];
    upd_valid = uv;
    upd_index = ui[IW-1:0];
    upd_way = uw[1:0];
    e.kind = 0;
    e.val = 3'b000;
    if (r) begin
      m_init = 1'b1;
      m_cnt = 0;
      e.kind = 2;
      armed = 1'b1;
    end else if (m_init) begin
      if (f) m_cnt = 0;
      else begin
        forget(m_cnt);
        if (m_cnt == NS - 1) m_init = 1'b0;
        m_cnt = (m_cnt + 1) % NS;
      end
    end else if (f) begin
      m_init = 1'b1;
      m_cnt = 0;
    end else begin
      if (uv) touch(ui, uw);
      if (rv) begin
        e.kind = 1;
        e.val = tree(ri);
      end
    end
    sbq.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input int i, input int w);
    cycle(0, 0, 0, 0, 1, i, w);
  endtask

  task automatic rd_chk(input int i, input logic [2:0] exp,
                        input string nm);
    cycle(0, 0, 1, i, 0, 0, 0);
    #1;
    chk(nm, {5'd0, plru_out}, {5'd0, exp});
    chk({nm, "_vld"}, {7'd0, plru_valid}, 8'd1);
  endtask

  // Counts cycles with ready low, issuing ignored traffic to set g.
  task automatic wait_ready(input int g, input string nm);
    int n;
    n = 1;
    for (int k = 0; k < 64; k++) begin
      cycle(0, 0, 1, g, 1, g, 3);
      #1;
      if (ready) break;
      n++;
    end
    chk(nm, n[7:0], 8'd16);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.kind == 1) begin
          chk("rd_vld", {7'd0, plru_valid}, 8'd1);
          chk("rd_data", {5'd0, plru_out}, {5'd0, e.val});
          last_out = e.val;
        end else if (e.kind == 2) begin
          chk("rst_vld", {7'd0, plru_valid}, 8'd0);
          chk("rst_out", {5'd0, plru_out}, 8'd0);
          last_out = 3'b000;
        end else begin
          chk("no_vld", {7'd0, plru_valid}, 8'd0);
          chk("hold_out", {5'd0, plru_out}, {5'd0, last_out});
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit r, f, rv, uv;
    for (int s = 0; s < NS; s++) forget(s);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 4, 1, 4, 0);
    wait_ready(6, "init_len");
    for (int s = 0; s < NS; s++) rd_chk(s, 3'b000, "init_rd");

    upd(5, 0);
    upd(5, 2);
    rd_chk(5, 3'b011, "set5_w0w2");
    idle();

    cycle(0, 0, 1, 3, 1, 3, 1);
    #1;
    chk("bypass_s3", {5'd0, plru_out}, 8'b100);

    upd(7, 0);
    upd(7, 1);
    upd(7, 2);
    upd(7, 3);
    rd_chk(7, 3'b000, "set7_all");

    upd(2, 2);
    upd(2, 0);
    rd_chk(2, 3'b111, "set2_pre");
    cycle(0, 1, 0, 0, 1, 2, 1);
    wait_ready(2, "flush_len");
    rd_chk(2, 3'b000, "set2_post");

    cycle(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) idle();
    cycle(1, 0, 1, 1, 0, 0, 0);
    wait_ready(1, "rst9_len");

    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 399) == 0);
      f = !r && ($urandom_range(0, 149) == 0);
      rv = !f && ($urandom_range(0, 1) == 1);
      uv = ($urandom_range(0, 2) != 0);
      cycle(r, f, rv, $urandom_range(0, NS - 1), uv,
            $urandom_range(0, NS - 1), $urandom_range(0, 3));
    end
    for (int k = 0; k < 20; k++) idle();
    #2;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/plru_state_array.md
PLRU_STATE_ARRAY -- requirements
Module: plru_state_array

Interface
REQ-001 SHALL have parameter NUM_SETS, default 16, the number of cache sets (power of two, 2..256).
REQ-002 SHALL have parameter IDX_W, default 4, the set index width, equal to log2(NUM_SETS).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port flush  input  1  pulse that starts a re-initialisation sweep of all sets.
REQ-006 SHALL have port ready  output  1  high when the array accepts reads and updates.
REQ-007 SHALL have port rd_valid  input  1  read request for rd_index.
REQ-008 SHALL have port rd_index  input  IDX_W  set to read.
REQ-009 SHALL have port plru_out  output  3  tree bits of the read set; bit 2 = root, bit 1 = left, bit 0 = right.
REQ-010 SHALL have port plru_valid  output  1  one-cycle pulse marking plru_out as newly loaded.
REQ-011 SHALL have port upd_valid  input  1  access (hit or fill) notification.
REQ-012 SHALL have port upd_index  input  IDX_W  set accessed.
REQ-013 SHALL have port upd_way  input  2  way accessed, 0..3.

Function
REQ-014 SHALL hold NUM_SETS x 3-bit tree entries.
- Root 0: LRU is in ways 0/1.
- Left 0: way0 is LRU; left 1: way1 is LRU.
- Right 0: way2 is LRU; right 1: way3 is LRU.
REQ-015 SHALL implement a two-state FSM, INIT and IDLE.
REQ-016 In INIT, it SHALL write 3'b000 to one set per cycle, from index 0 upward, using an IDX_W-bit sweep counter.
REQ-017 After writing set NUM_SETS-1, it SHALL go to IDLE on the next edge; the sweep takes exactly NUM_SETS cycles.
REQ-018 ready SHALL be 0 in INIT and 1 in IDLE.
REQ-019 flush sampled high in IDLE SHALL enter INIT with the sweep counter at 0.
REQ-020 flush sampled high in INIT SHALL restart the sweep counter at 0.
REQ-021 While ready=0, rd_valid and upd_valid SHALL be ignored; no entry changes except by the sweep, and plru_valid stays 0.
REQ-022 An update in IDLE SHALL modify only entry upd_index, as follows; any bit not listed keeps its value.
- way0: root=1, left=1.
- way1: root=1, left=0.
- way2: root=0, right=1.
- way3: root=0, right=0.
REQ-023 A read in IDLE SHALL have one-cycle latency: on the edge after rd_valid, plru_out is loaded with the entry and plru_valid=1 for that one cycle.
REQ-024 When a read and an update to the same index are sampled on the same edge, plru_out SHALL carry the post-update value (write-first bypass).
REQ-025 A read and an update to different indices on the same edge SHALL both complete without interfering.
REQ-026 plru_out SHALL hold its last loaded value while no read completes, including throughout INIT.
REQ-027 flush and upd_valid sampled on the same edge in IDLE: flush SHALL win, the update is dropped, and INIT begins.

Reset
REQ-028 rst SHALL take priority over flush and over all requests.
REQ-029 On reset, the FSM SHALL go to INIT with sweep counter=0, plru_out=3'b000, plru_valid=0 and ready=0.
REQ-030 Reset sampled mid-sweep or mid-read SHALL restart the sweep from index 0; no pending read completes.
REQ-031 The entry array SHALL NOT be reset directly; it is cleared only by the INIT sweep.

Verification
REQ-032 The bench SHALL cover: release rst -> ready=0 for exactly 16 cycles, then 1; reading every set then returns 3'b000.
REQ-033 The bench SHALL cover: updates to set 5 with way0, then way2, then a read of set 5 -> plru_out=3'b011 one cycle after rd_valid, with plru_valid pulsing once.
REQ-034 The bench SHALL cover: set 3 = 3'b000, then a read and an update (way1) of set 3 on the same edge -> plru_out=3'b100.
REQ-035 The bench SHALL cover: updates to set 7 with ways 0, 1, 2, 3 in consecutive cycles, then a read -> plru_out=3'b000.
REQ-036 The bench SHALL cover: flush asserted in IDLE after set 2 = 3'b111 -> ready low 16 cycles, updates ignored, then a read of set 2 -> 3'b000.
REQ-037 The bench SHALL cover: rst asserted at sweep index 9 -> the sweep restarts at 0, and ready rises 16 cycles after rst is released.
